mdu_unit: RTL and testbench

- Multiply/divide unit in the execute (E) stage, directly downstream of the instruction decoder.
- Consumes the decoder's 4-bit MDUControl code plus forwarded rs/rt operands.
- Owns the architectural HI/LO registers, models multi-cycle mult/div latency, and exports Start/Busy so the hazard unit can stall dependent MDU instructions in D.

---
 rtl/mdu_unit.sv | 135 +++++++++++++
 tb/tb_mdu_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, computes the result in the
// accept cycle and holds it pending until a fixed-latency countdown expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        div_b, quot_u, rem_u;
    logic signed [31:0] quot_s, rem_s;
    logic               div_ovf, is_arith;

    // The divisor is forced to 1 for the overflow and zero cases so the divider
    // never sees an undefined operation; those results are overridden anyway.
    always_comb begin
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        div_b   = (div_ovf || (B == 32'd0)) ? 32'd1 : B;
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        quot_s  = $signed(A) / $signed(div_b);
        rem_s   = $signed(A) % $signed(div_b);
        quot_u  = A / div_b;
        rem_u   = A % div_b;
    end

    always_comb begin
        is_arith  = (MDUControl >= OP_MULT) && (MDUControl <= OP_DIVU);
        Start     = is_arith && !busy_q;

        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        if (busy_q) begin
            // New ops and moves are dropped while an operation is in flight.
            cnt_d = cnt_q - CNT_ONE;
            if ((cnt_q == CNT_ONE) && pend_wr_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else begin
            case (MDUControl)
                OP_MULT: begin
                    pend_d    = prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = MULT_N;
                end
                OP_MULTU: begin
                    pend_d    = prod_u;
                    pend_wr_d = 1'b1;
                    cnt_d     = MULT_N;
                end
                OP_DIV: begin
                    pend_d    = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quot_s};
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = DIV_N;
                end
                OP_DIVU: begin
                    pend_d    = {rem_u, quot_u};
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = DIV_N;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);

        case (MDUControl)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: inputs driven 1ns after the rising edge, outputs sampled
// 1ns later; expected HI/LO come from a 64-bit arithmetic model via exp_q.
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, mdu_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi, m_lo;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .MDUControl(op), .A(a), .B(b),
        .Start(start), .Busy(busy), .HI(hi), .LO(lo), .MDUOut(mdu_out)
    );

    // Architectural result of one op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] h,
                                           input logic [31:0] l);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ref_op = {h, l};
        case (o)
            4'd1: ref_op = sx * sy;
            4'd2: ref_op = ux * uy;
            4'd3: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                ref_op = {r[31:0], q[31:0]};
            end
            4'd4: if (y != 0) begin
                uq = ux / uy;
                ur = ux % uy;
                ref_op = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a  = x;
        b  = y;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        n_tests++;
        if ({busy, hi, lo} !== 65'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, expected all zero", busy, hi, lo);
        end
        drive(4'd1, 32'd3, 32'd4);
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_start_comb: got %b expected 1", start);
        end
        drive(4'd0, 32'd0, 32'd0);
        n_tests++;
        if ({start, mdu_out} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: start=%b mdu_out=%h expected 0/0", start, mdu_out);
        end
        reset = 1'b0;
        tick();
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    // Fixed vectors then random ops, issued back to back at each completion cycle.
    task automatic test_mult_div(input int n_random);
        logic [3:0]  t_op [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd1, 4'd2, 4'd3};
        logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'h80000000, 32'h80000000, 32'h12345678, 32'd7};
        logic [31:0] t_b  [8] = '{32'd2, 32'd2, 32'd2, 32'd2,
                                  32'hFFFFFFFF, 32'h80000000, 32'h9ABCDEF0, 32'hFFFFFFFE};
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int          n;
        for (int i = 0; i < 8 + n_random; i++) begin
            if (i < 8) begin
                o = t_op[i]; x = t_a[i]; y = t_b[i];
            end else begin
                o = 4'($urandom_range(1, 4));
                x = $urandom;
                y = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            n = (o <= 4'd2) ? MULT_N : DIV_N;
            drive(o, x, y);
            n_tests++;
            if ({start, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL accept_%0d: start/busy=%b%b expected 10", i, start, busy);
            end
            exp_q.push_back(ref_op(o, x, y, m_hi, m_lo));
            tick();
            for (int k = 1; k <= n; k++) begin
                drive(4'd0, $urandom, $urandom);
                n_tests++;
                if ({busy, hi, lo} !== {1'b1, m_hi, m_lo}) begin
                    n_fail++;
                    $display("FAIL busy_%0d_c%0d: busy=%b hi=%h lo=%h expected 1 %h %h",
                             i, k, busy, hi, lo, m_hi, m_lo);
                end
                tick();
            end
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, hi, lo} !== {1'b0, e}) begin
                n_fail++;
                $display("FAIL result_%0d op%0d a=%h b=%h: busy=%b hi=%h lo=%h expected 0 %h %h",
                         i, o, x, y, busy, hi, lo, e[63:32], e[31:0]);
            end
            {m_hi, m_lo} = e;
        end
    endtask

    task automatic test_busy_ignored();
        logic [63:0] e;
        drive(4'd2, 32'hFFFFFFFF, 32'd2);
        e = ref_op(4'd2, 32'hFFFFFFFF, 32'd2, m_hi, m_lo);
        tick();
        for (int k = 1; k <= MULT_N; k++) begin
            case (k)
                2: drive(4'd5, 32'd0, 32'd0);
                3: drive(4'd2, 32'd5, 32'd7);
                4: drive(4'd7, 32'hDEADBEEF, 32'd0);
                5: drive(4'd8, 32'hDEADBEEF, 32'd0);
                default: drive(4'd0, 32'd0, 32'd0);
            endcase
            n_tests++;
            if ({start, busy, hi, lo} !== {2'b01, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL ignored_c%0d: start=%b busy=%b hi=%h lo=%h expected 0 1 %h %h",
                         k, start, busy, hi, lo, m_hi, m_lo);
            end
            if (k == 2) begin
                n_tests++;
                if (mdu_out !== m_hi) begin
                    n_fail++;
                    $display("FAIL mfhi_during_busy: got %h expected %h", mdu_out, m_hi);
                end
            end
            tick();
        end
        drive(4'd0, 32'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({busy, hi, lo} !== {1'b0, 32'h00000001, 32'hFFFFFFFE} || e !== 64'h1_FFFFFFFE) begin
                n_fail++;
                $display("FAIL multu_ignored_result_%0d: busy=%b hi=%h lo=%h expected 0 00000001 fffffffe",
                         k, busy, hi, lo);
            end
            tick();
        end
        {m_hi, m_lo} = e;
    endtask

    task automatic test_move();
        drive(4'd7, 32'h12345678, 32'd0);
        n_tests++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_start: got %b expected 0", start);
        end
        tick();
        m_hi = 32'h12345678;
        drive(4'd6, 32'd0, 32'd0);
        n_tests++;
        if (mdu_out !== m_lo) begin
            n_fail++;
            $display("FAIL mflo: got %h expected %h", mdu_out, m_lo);
        end
        drive(4'd5, 32'd0, 32'd0);
        n_tests++;
        if ({mdu_out, hi, lo} !== {32'h12345678, 32'h12345678, m_lo}) begin
            n_fail++;
            $display("FAIL mfhi_after_mthi: out=%h hi=%h lo=%h expected 12345678 12345678 %h",
                     mdu_out, hi, lo, m_lo);
        end
        tick();
        drive(4'd8, 32'hCAFEBABE, 32'd0);
        tick();
        m_lo = 32'hCAFEBABE;
        drive(4'd12, 32'h55555555, 32'd1);
        n_tests++;
        if ({mdu_out, start, hi, lo} !== {32'd0, 1'b0, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL mtlo_then_op12: out=%h start=%b hi=%h lo=%h expected 0 0 %h %h",
                     mdu_out, start, hi, lo, m_hi, m_lo);
        end
        tick();
        n_tests++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL op12_no_change: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo);
        end
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_div_zero();
        for (int j = 0; j < 2; j++) begin
            drive(4'(3 + j), 32'h00001234, 32'd0);
            n_tests++;
            if (start !== 1'b1) begin
                n_fail++;
                $display("FAIL divzero_start_%0d: got %b expected 1", j, start);
            end
            tick();
            for (int k = 1; k <= DIV_N; k++) begin
                drive(4'd0, 32'd0, 32'd0);
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL divzero_busy_%0d_c%0d: got %b expected 1", j, k, busy);
                end
                tick();
            end
            n_tests++;
            if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL divzero_result_%0d: busy=%b hi=%h lo=%h expected 0 %h %h",
                         j, busy, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'd1, 32'hFFFFFFFF, 32'd2);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy_c3: got %b expected 1", busy);
        end
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int k = 4; k <= 8; k++) begin
            n_tests++;
            if ({busy, hi, lo} !== 65'd0) begin
                n_fail++;
                $display("FAIL reset_mid_c%0d: busy=%b hi=%h lo=%h expected all zero", k, busy, hi, lo);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e_mul, e_div;
        drive(4'd1, 32'd3, 32'hFFFFFFFC);
        e_mul = ref_op(4'd1, 32'd3, 32'hFFFFFFFC, m_hi, m_lo);
        tick();
        drive(4'd0, 32'd0, 32'd0);
        repeat (MULT_N) tick();
        n_tests++;
        if ({busy, hi, lo} !== {1'b0, e_mul} || e_mul !== 64'hFFFFFFFF_FFFFFFF4) begin
            n_fail++;
            $display("FAIL b2b_mult_c6: busy=%b hi=%h lo=%h expected 0 ffffffff fffffff4", busy, hi, lo);
        end
        drive(4'd3, 32'd100, 32'd7);
        e_div = ref_op(4'd3, 32'd100, 32'd7, e_mul[63:32], e_mul[31:0]);
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_div_start: got %b expected 1", start);
        end
        tick();
        for (int k = 7; k <= 6 + DIV_N; k++) begin
            drive(4'd0, 32'd0, 32'd0);
            n_tests++;
            if ({busy, hi, lo} !== {1'b1, e_mul}) begin
                n_fail++;
                $display("FAIL b2b_c%0d: busy=%b hi=%h lo=%h expected 1 %h %h",
                         k, busy, hi, lo, e_mul[63:32], e_mul[31:0]);
            end
            tick();
        end
        n_tests++;
        if ({busy, hi, lo} !== {1'b0, 32'd2, 32'd14} || e_div !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL b2b_div_c17: busy=%b hi=%h lo=%h expected 0 00000002 0000000e", busy, hi, lo);
        end
        {m_hi, m_lo} = e_div;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_mult_div(16);
        test_busy_ignored();
        test_move();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
